// File: rtl/clkdiv_pkg.sv
// Shared types and defaults for the clock-divider family and the divided-clock monitor.
package clkdiv_pkg;

    localparam int CNT_W_DEF       = 32'd8;
    localparam int SYNC_STAGES_DEF = 32'd2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } clkdiv_state_t;

    // True when a signed high-minus-low difference is within one cycle of balance.
    function automatic logic duty_in_tol(input int diff);
        duty_in_tol = (diff >= -32'sd1) && (diff <= 32'sd1);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Synchronizes an asynchronous level into clk and reports its rising and falling edges.
import clkdiv_pkg::*;

module sync_edge_det #(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic s,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchronizer chain plus the previous-sample flop used for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign s    = sync_r[SYNC_STAGES-1];
    assign rise = s & ~prev_r;
    assign fall = ~s & prev_r;

endmodule

// File: rtl/div_clk_monitor.sv
// Measures high time, low time and period of a divided clock in source-clock cycles
// and flags period, duty and stuck-input errors.
import clkdiv_pkg::*;

module div_clk_monitor #(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             div_clk_in,
    input  logic [CNT_W-1:0] exp_period,
    output logic             meas_valid,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] low_cnt,
    output logic [CNT_W:0]   period,
    output logic             period_ok,
    output logic             duty_ok,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic                s_s;
    logic                rise_s;
    logic                fall_s;
    clkdiv_state_t       state_r;
    clkdiv_state_t       state_s;
    logic [CNT_W-1:0]    hc_r;
    logic [CNT_W-1:0]    hc_s;
    logic [CNT_W-1:0]    lc_r;
    logic [CNT_W-1:0]    lc_s;
    logic                meas_s;
    logic                timeout_s;
    logic [CNT_W:0]      sum_s;
    logic signed [CNT_W:0] diff_s;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (div_clk_in),
        .s        (s_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    assign sum_s  = {1'b0, hc_r} + {1'b0, lc_r};
    assign diff_s = $signed({1'b0, hc_r}) - $signed({1'b0, lc_r});

    // Next-state, counter and flag logic; disable overrides every edge, an edge overrides saturation.
    always_comb begin
        state_s   = state_r;
        hc_s      = hc_r;
        lc_s      = lc_r;
        meas_s    = 1'b0;
        timeout_s = timeout;
        if (!enable) begin
            state_s   = IDLE;
            hc_s      = '0;
            lc_s      = '0;
            timeout_s = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = WAIT_RISE;
                    hc_s    = '0;
                    lc_s    = '0;
                end
                WAIT_RISE: begin
                    if (rise_s) begin
                        state_s = MEAS_HIGH;
                        hc_s    = CNT_ONE;
                        lc_s    = '0;
                    end else begin
                        hc_s = '0;
                        lc_s = '0;
                    end
                end
                MEAS_HIGH: begin
                    if (fall_s) begin
                        state_s = MEAS_LOW;
                        lc_s    = CNT_ONE;
                    end else if (hc_r == CNT_MAX) begin
                        state_s   = WAIT_RISE;
                        hc_s      = '0;
                        lc_s      = '0;
                        timeout_s = 1'b1;
                    end else if (s_s) begin
                        hc_s = hc_r + CNT_ONE;
                    end else begin
                        hc_s = hc_r;
                    end
                end
                MEAS_LOW: begin
                    if (rise_s) begin
                        state_s   = MEAS_HIGH;
                        hc_s      = CNT_ONE;
                        lc_s      = '0;
                        meas_s    = 1'b1;
                        timeout_s = 1'b0;
                    end else if (lc_r == CNT_MAX) begin
                        state_s   = WAIT_RISE;
                        hc_s      = '0;
                        lc_s      = '0;
                        timeout_s = 1'b1;
                    end else if (!s_s) begin
                        lc_s = lc_r + CNT_ONE;
                    end else begin
                        lc_s = lc_r;
                    end
                end
                default: begin
                    state_s = IDLE;
                    hc_s    = '0;
                    lc_s    = '0;
                end
            endcase
        end
    end

    // FSM state and running counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            hc_r    <= '0;
            lc_r    <= '0;
        end else begin
            state_r <= state_s;
            hc_r    <= hc_s;
            lc_r    <= lc_s;
        end
    end

    // Result registers update only when a full period completes, then hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            low_cnt    <= '0;
            period     <= '0;
            period_ok  <= 1'b0;
            duty_ok    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            meas_valid <= meas_s;
            timeout    <= timeout_s;
            if (meas_s) begin
                high_cnt  <= hc_r;
                low_cnt   <= lc_r;
                period    <= sum_s;
                period_ok <= (sum_s == {1'b0, exp_period});
                duty_ok   <= duty_in_tol(int'(diff_s));
            end
        end
    end

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed self-checking bench for div_clk_monitor with hand-computed expectations.
module tb_div_clk_monitor;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       div_clk_in;
    logic [7:0] exp_period;
    logic       meas_valid;
    logic [7:0] high_cnt;
    logic [7:0] low_cnt;
    logic [8:0] period;
    logic       period_ok;
    logic       duty_ok;
    logic       timeout;

    int   checks;
    int   errors;
    int   cyc;
    int   pulses;
    int   first_pulse;
    int   last_pulse;
    int   gap_min;
    int   gap_max;
    logic timeout_seen;

    div_clk_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .div_clk_in (div_clk_in),
        .exp_period (exp_period),
        .meas_valid (meas_valid),
        .high_cnt   (high_cnt),
        .low_cnt    (low_cnt),
        .period     (period),
        .period_ok  (period_ok),
        .duty_ok    (duty_ok),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    task automatic clear_stats();
        cyc          = 0;
        pulses       = 0;
        first_pulse  = -1;
        last_pulse   = -1;
        gap_min      = 100000;
        gap_max      = 0;
        timeout_seen = 1'b0;
    endtask

    task automatic step(input logic b);
        int gap;
        div_clk_in = b;
        @(posedge clk);
        #1;
        if (meas_valid === 1'b1) begin
            pulses++;
            if (first_pulse < 0) first_pulse = cyc;
            if (last_pulse >= 0) begin
                gap = cyc - last_pulse;
                if (gap < gap_min) gap_min = gap;
                if (gap > gap_max) gap_max = gap;
            end
            last_pulse = cyc;
        end
        if (timeout === 1'b1) timeout_seen = 1'b1;
        cyc++;
    endtask

    task automatic run_pattern(input logic [15:0] pat, input int len, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < len; i++) begin
                step(pat[len-1-i]);
            end
        end
    endtask

    task automatic idle_gap();
        enable = 1'b0;
        repeat (4) step(1'b0);
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        enable     = 1'b0;
        div_clk_in = 1'b0;
        exp_period = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_meas_valid: got %0b want 0", meas_valid); end
        checks++; if (high_cnt !== 8'd0) begin errors++; $display("FAIL reset_high_cnt: got %0d want 0", high_cnt); end
        checks++; if (low_cnt !== 8'd0) begin errors++; $display("FAIL reset_low_cnt: got %0d want 0", low_cnt); end
        checks++; if (period !== 9'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
        checks++; if ({period_ok, duty_ok, timeout} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {period_ok, duty_ok, timeout}); end
        reset = 1'b0;
    endtask

    task automatic test_div3();
        clear_stats();
        exp_period = 8'd3;
        enable     = 1'b1;
        run_pattern(16'b110, 3, 10);
        checks++; if (first_pulse !== 5) begin errors++; $display("FAIL div3_first_pulse: got %0d want 5", first_pulse); end
        checks++; if (pulses !== 9) begin errors++; $display("FAIL div3_pulses: got %0d want 9", pulses); end
        checks++; if (gap_min !== 3 || gap_max !== 3) begin errors++; $display("FAIL div3_gap: got %0d..%0d want 3..3", gap_min, gap_max); end
        checks++; if (high_cnt !== 8'd2) begin errors++; $display("FAIL div3_high: got %0d want 2", high_cnt); end
        checks++; if (low_cnt !== 8'd1) begin errors++; $display("FAIL div3_low: got %0d want 1", low_cnt); end
        checks++; if (period !== 9'd3) begin errors++; $display("FAIL div3_period: got %0d want 3", period); end
        checks++; if ({period_ok, duty_ok, timeout} !== 3'b110) begin errors++; $display("FAIL div3_flags: got %b want 110", {period_ok, duty_ok, timeout}); end
    endtask

    task automatic test_div4();
        idle_gap();
        clear_stats();
        exp_period = 8'd3;
        enable     = 1'b1;
        run_pattern(16'b1100, 4, 6);
        checks++; if (pulses !== 5) begin errors++; $display("FAIL div4_pulses: got %0d want 5", pulses); end
        checks++; if (gap_min !== 4 || gap_max !== 4) begin errors++; $display("FAIL div4_gap: got %0d..%0d want 4..4", gap_min, gap_max); end
        checks++; if (high_cnt !== 8'd2 || low_cnt !== 8'd2) begin errors++; $display("FAIL div4_counts: got %0d/%0d want 2/2", high_cnt, low_cnt); end
        checks++; if (period !== 9'd4) begin errors++; $display("FAIL div4_period: got %0d want 4", period); end
        checks++; if ({period_ok, duty_ok} !== 2'b01) begin errors++; $display("FAIL div4_flags: got %b want 01", {period_ok, duty_ok}); end
        idle_gap();
        clear_stats();
        enable = 1'b1;
        run_pattern(16'b1000, 4, 6);
        checks++; if (pulses !== 5) begin errors++; $display("FAIL skew_pulses: got %0d want 5", pulses); end
        checks++; if (high_cnt !== 8'd1 || low_cnt !== 8'd3) begin errors++; $display("FAIL skew_counts: got %0d/%0d want 1/3", high_cnt, low_cnt); end
        checks++; if (period !== 9'd4) begin errors++; $display("FAIL skew_period: got %0d want 4", period); end
        checks++; if ({period_ok, duty_ok} !== 2'b00) begin errors++; $display("FAIL skew_flags: got %b want 00", {period_ok, duty_ok}); end
    endtask

    task automatic test_timeout();
        idle_gap();
        clear_stats();
        exp_period = 8'd3;
        enable     = 1'b1;
        run_pattern(16'b110, 3, 4);
        for (int i = 0; i < 300; i++) begin
            step(1'b1);
            if (i == 5) clear_stats();
            if (i == 256) begin
                checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %0b want 0 at 255 counts", timeout); end
            end
            if (i == 257) begin
                checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_onset: got %0b want 1 past 255 counts", timeout); end
            end
        end
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %0b want 1", timeout); end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL timeout_no_meas: got %0d pulses want 0", pulses); end
        checks++; if (high_cnt !== 8'd2 || low_cnt !== 8'd1 || period !== 9'd3) begin errors++; $display("FAIL timeout_hold: got %0d/%0d/%0d want 2/1/3", high_cnt, low_cnt, period); end
        step(1'b0);
        checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_before_meas: got %0b want 1", timeout); end
        clear_stats();
        run_pattern(16'b110, 3, 4);
        checks++; if (pulses !== 3) begin errors++; $display("FAIL restore_pulses: got %0d want 3", pulses); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL restore_timeout: got %0b want 0", timeout); end
        checks++; if (period !== 9'd3 || high_cnt !== 8'd2) begin errors++; $display("FAIL restore_result: got period %0d high %0d want 3/2", period, high_cnt); end
    endtask

    task automatic test_enable_drop();
        idle_gap();
        clear_stats();
        exp_period = 8'd4;
        enable     = 1'b1;
        run_pattern(16'b1100, 4, 3);
        checks++; if (pulses !== 2) begin errors++; $display("FAIL en_setup_pulses: got %0d want 2", pulses); end
        clear_stats();
        step(1'b0);
        enable = 1'b0;
        run_pattern(16'b1100, 4, 3);
        checks++; if (pulses !== 0) begin errors++; $display("FAIL en_drop_no_meas: got %0d want 0", pulses); end
        checks++; if (high_cnt !== 8'd2 || low_cnt !== 8'd2 || period !== 9'd4) begin errors++; $display("FAIL en_drop_hold: got %0d/%0d/%0d want 2/2/4", high_cnt, low_cnt, period); end
        checks++; if ({period_ok, duty_ok, timeout} !== 3'b110) begin errors++; $display("FAIL en_drop_flags: got %b want 110", {period_ok, duty_ok, timeout}); end
        repeat (4) step(1'b1);
        clear_stats();
        enable = 1'b1;
        run_pattern(16'b1100011101111, 13, 1);
        checks++; if (pulses !== 1) begin errors++; $display("FAIL en_high_pulses: got %0d want 1", pulses); end
        checks++; if (first_pulse !== 11) begin errors++; $display("FAIL en_high_first: got %0d want 11", first_pulse); end
        checks++; if (high_cnt !== 8'd3 || low_cnt !== 8'd1 || period !== 9'd4) begin errors++; $display("FAIL en_high_result: got %0d/%0d/%0d want 3/1/4", high_cnt, low_cnt, period); end
        checks++; if ({period_ok, duty_ok} !== 2'b10) begin errors++; $display("FAIL en_high_flags: got %b want 10", {period_ok, duty_ok}); end
    endtask

    task automatic test_async_reset();
        repeat (3) step(1'b1);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL areset_meas_valid: got %0b want 0", meas_valid); end
        checks++; if (high_cnt !== 8'd0 || low_cnt !== 8'd0) begin errors++; $display("FAIL areset_counts: got %0d/%0d want 0/0", high_cnt, low_cnt); end
        checks++; if (period !== 9'd0) begin errors++; $display("FAIL areset_period: got %0d want 0", period); end
        checks++; if ({period_ok, duty_ok, timeout} !== 3'b000) begin errors++; $display("FAIL areset_flags: got %b want 000", {period_ok, duty_ok, timeout}); end
        enable     = 1'b0;
        div_clk_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_stats();
        exp_period = 8'd3;
        enable     = 1'b1;
        run_pattern(16'b110, 3, 10);
        checks++; if (first_pulse !== 5) begin errors++; $display("FAIL cold_first_pulse: got %0d want 5", first_pulse); end
        checks++; if (pulses !== 9) begin errors++; $display("FAIL cold_pulses: got %0d want 9", pulses); end
        checks++; if (high_cnt !== 8'd2 || low_cnt !== 8'd1 || period !== 9'd3) begin errors++; $display("FAIL cold_result: got %0d/%0d/%0d want 2/1/3", high_cnt, low_cnt, period); end
    endtask

    task automatic test_sat_edge();
        idle_gap();
        clear_stats();
        exp_period = 8'd3;
        enable     = 1'b1;
        repeat (2) step(1'b0);
        repeat (255) step(1'b1);
        repeat (2) step(1'b0);
        repeat (3) step(1'b1);
        checks++; if (timeout_seen !== 1'b0) begin errors++; $display("FAIL sat_edge_timeout: got %0b want 0", timeout_seen); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL sat_edge_pulses: got %0d want 1", pulses); end
        checks++; if (high_cnt !== 8'd255 || low_cnt !== 8'd2) begin errors++; $display("FAIL sat_edge_counts: got %0d/%0d want 255/2", high_cnt, low_cnt); end
        checks++; if (period !== 9'd257) begin errors++; $display("FAIL sat_edge_period: got %0d want 257", period); end
        checks++; if ({period_ok, duty_ok} !== 2'b00) begin errors++; $display("FAIL sat_edge_flags: got %b want 00", {period_ok, duty_ok}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_stats();
        test_reset();
        test_div3();
        test_div4();
        test_timeout();
        test_enable_drop();
        test_async_reset();
        test_sat_edge();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
